// File: rtl/image_load.sv
// image_load: stream-to-memory loader for the noise-detection image path.
// Takes a 4-byte header (M, N) followed by M*N pixel beats from a valid/ready
// stream and writes each pixel into the image RAM through a registered port.
module image_load #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  loadEn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  we,
    output logic [15:0]           M,
    output logic [15:0]           N,
    output logic [31:0]           dataCount,
    output logic                  loadF,
    output logic                  loadErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    // Number of pixels the RAM can hold
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    state_t      state;
    logic [1:0]  hdr_cnt;
    logic [31:0] pix_idx;
    logic        accept;
    logic [31:0] product;

    // Ready depends on state only so the upstream never sees a combinational loop
    assign in_ready = (state == S_HDR) || (state == S_DATA);
    assign accept   = in_valid & in_ready;
    // 16x16 unsigned product always fits in 32 bits
    assign product  = {16'd0, M} * {16'd0, N};

    // Load sequencer: header capture, size check, pixel writes, completion flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            hdr_cnt   <= 2'd0;
            pix_idx   <= 32'd0;
            addr      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            M         <= 16'd0;
            N         <= 16'd0;
            dataCount <= 32'd0;
            loadF     <= 1'b0;
            loadErr   <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (loadEn) begin
                        state   <= S_HDR;
                        hdr_cnt <= 2'd0;
                        pix_idx <= 32'd0;
                        addr    <= '0;
                        loadF   <= 1'b0;
                        loadErr <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (!loadEn) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        case (hdr_cnt)
                            2'd0: M[15:8] <= in_data[7:0];
                            2'd1: M[7:0]  <= in_data[7:0];
                            2'd2: N[15:8] <= in_data[7:0];
                            2'd3: N[7:0]  <= in_data[7:0];
                            default: ;
                        endcase
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == 2'd3) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    dataCount <= product;
                    if (product > CAPACITY) begin
                        state   <= S_ERR;
                        loadErr <= 1'b1;
                    end else if (product == 32'd0) begin
                        state <= S_DONE;
                        loadF <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    // A beat accepted in the abort cycle is still written
                    if (accept) begin
                        we      <= 1'b1;
                        wdata   <= in_data;
                        addr    <= pix_idx[ADDR_WIDTH-1:0];
                        pix_idx <= pix_idx + 32'd1;
                    end
                    if (!loadEn) begin
                        state <= S_IDLE;
                    end else if (accept && (pix_idx == dataCount - 32'd1)) begin
                        state <= S_DONE;
                        loadF <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!loadEn) begin
                        state <= S_IDLE;
                        loadF <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (!loadEn) begin
                        state   <= S_IDLE;
                        loadErr <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_load.sv
// tb_image_load: randomized scoreboard bench for image_load.
// The driver pushes the expected RAM write (address, data, cycle) for every
// accepted pixel; an independent monitor pops and compares on each we pulse.
module tb_image_load;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          loadEn = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [15:0]   M;
    logic [15:0]   N;
    logic [31:0]   dataCount;
    logic          loadF;
    logic          loadErr;

    image_load #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .loadEn(loadEn), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .wdata(wdata),
        .we(we), .M(M), .N(N), .dataCount(dataCount), .loadF(loadF),
        .loadErr(loadErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    wr_t  cur;
    logic [DW-1:0] ram [0:CAP-1];
    int   exp_img [0:CAP-1];

    // Clock-edge counter used to check the one-cycle write latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && we) begin
            ram[addr] = wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write", addr, wdata);
            end else begin
                cur = exp_q.pop_front();
                $display("write addr=%0d data=%0d cyc=%0d", addr, wdata, cyc);
                chk("wr_addr", 32'(addr), cur.a);
                chk("wr_data", 32'(wdata), cur.d);
                chk("wr_cycle", cyc, cur.c);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_wdata"}, 32'(wdata), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_M"}, 32'(M), 0);
        chk({tag, "_N"}, 32'(N), 0);
        chk({tag, "_dataCount"}, dataCount, 0);
        chk({tag, "_loadF"}, 32'(loadF), 0);
        chk({tag, "_loadErr"}, 32'(loadErr), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    // Present one beat until accepted; pixels record the expected write
    task automatic send_beat(input logic [7:0] d, input bit pix, input int idx,
                             input bit stall, input bit drop);
        int guard = 0;
        forever begin
            @(negedge clk);
            #1;
            in_data  = d;
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop) loadEn = 1'b0;
            if (in_valid && in_ready) begin
                if (pix) exp_q.push_back('{idx, int'(d), cyc + 1});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            guard++;
            if (guard > 500) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: got no acceptance expected beat %0d accepted", idx);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    // One complete load. mode 1: drop loadEn with pixel cut; mode 2: reset before pixel cut
    task automatic do_load(input int m, input int n, input bit stall, input int cut,
                           input int mode, input bit fixed);
        int total;
        int d;
        total = m * n;
        $display("load M=%0d N=%0d stall=%0d cut=%0d mode=%0d", m, n, stall, cut, mode);
        @(negedge clk);
        loadEn = 1'b1;
        send_beat(8'(m >> 8), 1'b0, 0, stall, 1'b0);
        send_beat(8'(m & 255), 1'b0, 0, stall, 1'b0);
        send_beat(8'(n >> 8), 1'b0, 0, stall, 1'b0);
        send_beat(8'(n & 255), 1'b0, 0, stall, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("hdr_M", 32'(M), m);
        chk("hdr_N", 32'(N), n);
        chk("dataCount", dataCount, total);
        if (total > CAP) begin
            chk("err_loadErr", 32'(loadErr), 1);
            chk("err_in_ready", 32'(in_ready), 0);
            chk("err_loadF", 32'(loadF), 0);
            loadEn = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            chk("err_clear_loadErr", 32'(loadErr), 0);
            chk("err_no_writes", exp_q.size(), 0);
            return;
        end
        for (int i = 0; i < total; i++) begin
            d = fixed ? (10 + i) : int'($urandom_range(0, 255));
            exp_img[i] = d;
            if (mode == 2 && i == cut) begin
                @(negedge clk);
                #2;
                rst = 1'b0;
                #1;
                chk_zero("midrst");
                loadEn = 1'b0;
                exp_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (mode == 1 && i == cut) begin
                send_beat(8'(d), 1'b1, i, 1'b0, 1'b1);
                repeat (2) @(negedge clk);
                #1;
                chk("abort_loadF", 32'(loadF), 0);
                chk("abort_in_ready", 32'(in_ready), 0);
                chk("abort_pending", exp_q.size(), 0);
                chk("abort_dataCount", dataCount, total);
                return;
            end
            send_beat(8'(d), 1'b1, i, stall, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("done_loadF", 32'(loadF), 1);
        chk("done_in_ready", 32'(in_ready), 0);
        chk("done_pending", exp_q.size(), 0);
        if (total > 0) begin
            for (int i = 0; i < total; i += (total > 16 ? 37 : 1)) begin
                chk("ram_content", 32'(ram[i]), exp_img[i]);
            end
        end
        loadEn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_loadF", 32'(loadF), 0);
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("idle");

        do_load(2, 3, 1'b0, -1, 0, 1'b1);
        do_load(2, 3, 1'b1, -1, 0, 1'b1);
        do_load(16, 17, 1'b0, -1, 0, 1'b0);
        do_load(16, 16, 1'b0, -1, 0, 1'b0);
        do_load(0, 5, 1'b0, -1, 0, 1'b0);
        do_load(2, 3, 1'b0, 3, 2, 1'b1);
        do_load(2, 3, 1'b0, -1, 0, 1'b1);
        do_load(2, 3, 1'b0, 2, 1, 1'b1);
        do_load(2, 3, 1'b0, -1, 0, 1'b0);
        repeat (8) begin
            do_load(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)), -1, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        #1;
        chk("final_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
